// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle core: state sequencing, ALU decode, NZCV flags.
// Define COND_EXEC_EN for conditional execution; otherwise every instruction executes.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags,
  output logic [3:0] State,
  output logic       Undef
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB  = 4'd4,
    MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
  } state_t;

  state_t     state, state_next, view;
  logic       ir_w, next_pc, reg_w, mem_w, branch, alu_op, no_write, cond_ok;
  logic [1:0] flag_w;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   state_next = MEMADR;
          2'b00:   state_next = Funct[5] ? EXECI : EXECR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: state_next = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_next = MEMWB;
      EXECR:  state_next = ALUWB;
      EXECI:  state_next = ALUWB;
      default: state_next = FETCH;
    endcase
  end

  // Muxes present the FETCH view while reset is held.
  assign view  = rst_n ? state : FETCH;
  assign State = state;

  always_comb begin
    ir_w      = 1'b0;
    next_pc   = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (view)
      FETCH: begin
        ir_w = 1'b1; next_pc = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB:  begin ResultSrc = 2'b01; reg_w = 1'b1; end
      MEMWR:  begin AdrSrc = 1'b1; mem_w = 1'b1; end
      EXECR:  alu_op = 1'b1;
      EXECI:  begin ALUSrcB = 2'b01; alu_op = 1'b1; end
      ALUWB:  reg_w = 1'b1;
      BRANCH: begin ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = 2'b00;
    if (alu_op) begin
      case (Funct[4:1])
        4'b0010: ALUControl = 2'b01;
        4'b1010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: ALUControl = 2'b00;
      endcase
    end
  end

  // NoWrite follows the instruction, not ALUOp, so CMP stays suppressed in ALUWB.
  assign no_write  = (Op == 2'b00) & (Funct[4:1] == 4'b1010);
  assign flag_w[1] = alu_op & Funct[0];
  assign flag_w[0] = alu_op & Funct[0] & ~ALUControl[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Flags <= 4'b0000;
    end else begin
      if (flag_w[1] & cond_ok) Flags[3:2] <= ALUFlags[3:2];
      if (flag_w[0] & cond_ok) Flags[1:0] <= ALUFlags[1:0];
    end
  end

`ifdef COND_EXEC_EN
  logic cond_pass;

  always_comb begin
    cond_pass = 1'b0;
    case (Cond)
      4'b0000: cond_pass = Flags[2];
      4'b0001: cond_pass = ~Flags[2];
      4'b0010: cond_pass = Flags[1];
      4'b0011: cond_pass = ~Flags[1];
      4'b0100: cond_pass = Flags[3];
      4'b0101: cond_pass = ~Flags[3];
      4'b0110: cond_pass = Flags[0];
      4'b0111: cond_pass = ~Flags[0];
      4'b1000: cond_pass = Flags[1] & ~Flags[2];
      4'b1001: cond_pass = ~Flags[1] | Flags[2];
      4'b1010: cond_pass = (Flags[3] == Flags[0]);
      4'b1011: cond_pass = (Flags[3] != Flags[0]);
      4'b1100: cond_pass = ~Flags[2] & (Flags[3] == Flags[0]);
      4'b1101: cond_pass = Flags[2] | (Flags[3] != Flags[0]);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)              cond_ok <= 1'b0;
    else if (state == DECODE) cond_ok <= cond_pass;
  end
`else
  logic unused_cond;
  assign unused_cond = ^Cond;
  assign cond_ok     = 1'b1;
`endif

  assign IRWrite  = rst_n & ir_w;
  assign RegWrite = rst_n & reg_w & cond_ok & ~no_write;
  assign MemWrite = rst_n & mem_w & cond_ok;
  assign PCWrite  = rst_n & (next_pc | (branch & cond_ok) |
                             (reg_w & cond_ok & ~no_write & (Rd == 4'hF)));
  assign ImmSrc   = Op;
  assign RegSrc   = {Op == 2'b01, Op == 2'b10};
  assign Undef    = (view == DECODE) & (Op == 2'b11);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction-level reference model,
// directed scenarios plus randomized instruction streams.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd, Cond, ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, Undef;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic [3:0] Flags, State;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] m_flags;

`ifdef COND_EXEC_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  // Per-state mux settings {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB}, indexed by state code.
  localparam logic [5:0] MUX_TAB [0:9] = '{
    6'b0_10_1_10, 6'b0_10_1_10, 6'b0_00_0_01, 6'b1_00_0_00, 6'b0_01_0_00,
    6'b1_00_0_00, 6'b0_00_0_00, 6'b0_00_0_01, 6'b0_00_0_00, 6'b0_10_0_01
  };

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Flags(Flags), .State(State), .Undef(Undef)
  );

  always #5 clk = ~clk;

  function automatic bit cond_eval(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (!COND_EN) return 1'b1;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Runs one whole instruction starting in its FETCH cycle (just after a rising edge)
  // and compares every cycle's outputs with the instruction-level model.
  task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input logic [3:0] cond,
                           input logic [3:0] alf);
    logic [3:0] seq[$];
    logic [3:0] st, cmd, new_flags, e_flags;
    logic [1:0] e_alu, exp_alu;
    logic [5:0] mx;
    logic [24:0] got, exp;
    bit ok, dp, nw, writes_reg, last, e_irw, e_pcw, e_mw, e_rw, e_undef;

    Op = op; Funct = fn; Rd = rd; Cond = cond; ALUFlags = alf;
    seq = '{4'd0, 4'd1};
    case (op)
      2'b01: begin seq.push_back(4'd2); seq.push_back(fn[0] ? 4'd3 : 4'd5);
                   if (fn[0]) seq.push_back(4'd4); end
      2'b00: begin seq.push_back(fn[5] ? 4'd7 : 4'd6); seq.push_back(4'd8); end
      2'b10: seq.push_back(4'd9);
      default: ;
    endcase

    ok  = cond_eval(cond, m_flags);
    dp  = (op == 2'b00);
    cmd = fn[4:1];
    exp_alu = (cmd == 4'b0010 || cmd == 4'b1010) ? 2'd1 :
              (cmd == 4'b0000) ? 2'd2 : (cmd == 4'b1100) ? 2'd3 : 2'd0;
    nw  = dp && (cmd == 4'b1010);
    writes_reg = (op == 2'b01 && fn[0]) || (dp && !nw);
    new_flags = m_flags;
    if (dp && fn[0] && ok) begin
      new_flags[3:2] = alf[3:2];
      if (exp_alu <= 2'd1) new_flags[1:0] = alf[1:0];
    end

    for (int i = 0; i < seq.size(); i++) begin
      st      = seq[i];
      last    = (i == seq.size() - 1);
      e_irw   = (i == 0);
      e_pcw   = (i == 0) || (last && ok && (op == 2'b10 || (writes_reg && rd == 4'hF)));
      e_mw    = last && op == 2'b01 && !fn[0] && ok;
      e_rw    = last && writes_reg && ok;
      e_alu   = (dp && i == 2) ? exp_alu : 2'd0;
      e_undef = (i == 1) && (op == 2'b11);
      e_flags = (dp && i == 3) ? new_flags : m_flags;
      mx      = MUX_TAB[st];
      exp = {st, e_irw, e_pcw, e_mw, e_rw, mx[5], mx[4:3], mx[2], mx[1:0], e_alu,
             e_undef, e_flags, op, op == 2'b01, op == 2'b10};
      @(negedge clk);
      got = {State, IRWrite, PCWrite, MemWrite, RegWrite, AdrSrc, ResultSrc, ALUSrcA,
             ALUSrcB, ALUControl, Undef, Flags, ImmSrc, RegSrc};
      n_checks++;
      if (got !== exp)
        $display("FAIL %s cycle %0d: got %h expected %h", name, i, got, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
    m_flags = new_flags;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Op = 2'b01; Funct = 6'b011000; Rd = 4'd0; Cond = 4'hE; ALUFlags = 4'hF;
    #1;
    n_checks++;
    if ({IRWrite, PCWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} !== 10'b0000_0_1_10_10)
      $display("FAIL reset_comb: got %b expected 0000011010",
               {IRWrite, PCWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc});
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({State, Flags} !== 8'h00) $display("FAIL reset_state: got %h expected 00", {State, Flags});
    else n_pass++;
    rst_n = 1'b1; #1;
    n_checks++;
    if ({State, IRWrite, PCWrite} !== 6'b0000_11)
      $display("FAIL release_fetch: got %b expected 000011", {State, IRWrite, PCWrite});
    else n_pass++;
    m_flags = 4'b0000;
  endtask

  task automatic test_ldr_str();
    run_instr("ldr", 2'b01, 6'b011001, 4'd3, 4'hE, 4'($urandom));
    run_instr("ldr_pc", 2'b01, 6'b011001, 4'hF, 4'hE, 4'($urandom));
    run_instr("str", 2'b01, 6'b011000, 4'd4, 4'hE, 4'($urandom));
  endtask

  task automatic test_subs_beq();
    run_instr("subs", 2'b00, 6'b000101, 4'd1, 4'hE, 4'b0110);
    n_checks++;
    if (Flags !== 4'b0110) $display("FAIL subs_flags: got %b expected 0110", Flags);
    else n_pass++;
    run_instr("beq", 2'b10, 6'b101010, 4'd0, 4'b0000, 4'b0000);
  endtask

  task automatic test_addne();
    run_instr("addne", 2'b00, 6'b001000, 4'd2, 4'b0001, 4'b1111);
    run_instr("orr_imm", 2'b00, 6'b111001, 4'hF, 4'hE, 4'b1001);
  endtask

  task automatic test_cmp_undef();
    run_instr("cmp", 2'b00, 6'b010101, 4'd5, 4'hE, 4'b1000);
    n_checks++;
    if (Flags !== 4'b1000) $display("FAIL cmp_flags: got %b expected 1000", Flags);
    else n_pass++;
    run_instr("undef", 2'b11, 6'b000000, 4'hF, 4'hE, 4'b1111);
    run_instr("never", 2'b10, 6'b000000, 4'd0, 4'hF, 4'b0000);
  endtask

  task automatic test_reset_mid();
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd6; Cond = 4'hE; ALUFlags = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({State, MemWrite} !== 5'b0101_1)
      $display("FAIL mid_memwr: got %b expected 01011", {State, MemWrite});
    else n_pass++;
    rst_n = 1'b0; #1;
    n_checks++;
    if ({MemWrite, AdrSrc, ALUSrcA} !== 3'b001)
      $display("FAIL mid_reset_comb: got %b expected 001", {MemWrite, AdrSrc, ALUSrcA});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({State, Flags} !== 8'h00) $display("FAIL mid_reset_state: got %h expected 00", {State, Flags});
    else n_pass++;
    rst_n = 1'b1;
    m_flags = 4'b0000;
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++)
      run_instr("rand", 2'($urandom), 6'($urandom), 4'($urandom), 4'($urandom),
                4'($urandom));
  endtask

  initial begin
    test_reset();
    test_ldr_str();
    test_subs_beq();
    test_addne();
    test_cmp_undef();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
